// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// bp_pkg : shared constants for the branch history predictor. Rev 1.0
// ============================================================================
package bp_pkg;

    localparam logic [1:0] FORCE_NT   = 2'b00;
    localparam logic [1:0] FORCE_T    = 2'b11;
    localparam int         PC_IDX_OFS = 2;
    localparam int         STAT_W     = 16;

    function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// bp_sat_counter : saturating up/down counter, async active-low reset. Rev 1.0
// ============================================================================
module bp_sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] rst_val,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= rst_val;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_history_predictor.sv
`default_nettype none
// ============================================================================
// branch_history_predictor : bimodal / gshare table of saturating counters.
// Define BHP_GSHARE_EN for gshare indexing with a non-speculative GHR. Rev 1.0
// ============================================================================
module branch_history_predictor
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2,
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         lk_pc,
    input  logic [1:0]          forcer,
    output logic                jump,
    output logic [IDX_BITS-1:0] lk_idx,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                upd_mispred,
    output logic [STAT_W-1:0]   stat_branches,
    output logic [STAT_W-1:0]   stat_mispred
);

    localparam int                c_ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] c_RST_VAL = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_THRESH  = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [CTR_BITS-1:0] w_ctr [c_ENTRIES];
    logic [IDX_BITS-1:0] w_pc_idx;
    logic                w_unused_pc;
    logic [STAT_W-1:0]   r_branches;
    logic [STAT_W-1:0]   r_mispred;
    logic                w_jump;

    assign w_pc_idx    = lk_pc[IDX_BITS+PC_IDX_OFS-1:PC_IDX_OFS];
    assign w_unused_pc = ^{lk_pc[31:IDX_BITS+PC_IDX_OFS], lk_pc[PC_IDX_OFS-1:0]};

`ifdef BHP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;

    // History only advances on resolved branches, so a same-cycle lookup sees the old GHR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= GHR_BITS'({r_ghr, upd_taken});
        end
    end

    assign lk_idx = w_pc_idx ^ IDX_BITS'(r_ghr);
`else
    localparam int c_unused_ghr_bits = GHR_BITS;
    assign lk_idx = w_pc_idx;
`endif

    for (genvar gi = 0; gi < c_ENTRIES; gi++) begin : g_table
        logic w_hit;
        assign w_hit = upd_valid && (upd_idx == IDX_BITS'(gi));

        bp_sat_counter #(
            .WIDTH   (CTR_BITS)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .inc     (w_hit && upd_taken),
            .dec     (w_hit && !upd_taken),
            .rst_val (c_RST_VAL),
            .count   (w_ctr[gi])
        );
    end

    // Counters hold their reset value during reset, so the predictor path reads not-taken then.
    always_comb begin
        w_jump = 1'b0;
        case (forcer)
            FORCE_NT: w_jump = 1'b0;
            FORCE_T:  w_jump = 1'b1;
            default:  w_jump = (w_ctr[lk_idx] >= c_THRESH);
        endcase
    end

    assign jump = w_jump;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branches <= '0;
            r_mispred  <= '0;
        end else if (upd_valid) begin
            r_branches <= stat_sat_inc(r_branches);
            if (upd_mispred) begin
                r_mispred <= stat_sat_inc(r_mispred);
            end
        end
    end

    assign stat_branches = r_branches;
    assign stat_mispred  = r_mispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_history_predictor.sv
`default_nettype none
// ============================================================================
// tb_branch_history_predictor : directed self-checking bench. Rev 1.0
// ============================================================================
module tb_branch_history_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lk_pc;
    logic [1:0]  forcer;
    logic        jump;
    logic [5:0]  lk_idx;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispred;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [5:0]  m_ghr    = '0;

    branch_history_predictor #(
        .CTR_BITS      (2),
        .IDX_BITS      (6),
        .GHR_BITS      (6)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .lk_pc         (lk_pc),
        .forcer        (forcer),
        .jump          (jump),
        .lk_idx        (lk_idx),
        .upd_valid     (upd_valid),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .upd_mispred   (upd_mispred),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // PC whose table index equals idx under the current model history.
    function automatic logic [31:0] pc_for(input logic [5:0] idx);
`ifdef BHP_GSHARE_EN
        return 32'hABC0_0000 | (32'(idx ^ m_ghr) << 2);
`else
        return 32'hABC0_0000 | (32'(idx) << 2);
`endif
    endfunction

    task automatic look(input logic [5:0] idx);
        lk_pc = pc_for(idx);
        #1;
    endtask

    task automatic do_upd(input logic [5:0] idx, input logic tk, input logic mp);
        @(negedge clk);
        upd_valid   = 1'b1;
        upd_idx     = idx;
        upd_taken   = tk;
        upd_mispred = mp;
        @(posedge clk);
        #1;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        m_ghr       = {m_ghr[4:0], tk};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        m_ghr = '0;
        @(negedge clk);
        rst   = 1'b1;
    endtask

    initial begin
        int ones;
        rst         = 1'b0;
        lk_pc       = 32'h0000_0014;
        forcer      = 2'b11;
        upd_valid   = 1'b0;
        upd_idx     = '0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
        #1;
        check_eq("rst_force_t", jump, 1);
        forcer = 2'b00;
        #1;
        check_eq("rst_force_nt", jump, 0);
        check_eq("rst_stat_br", stat_branches, 0);
        check_eq("rst_stat_mp", stat_mispred, 0);
        @(negedge clk);
        rst    = 1'b1;
        forcer = 2'b01;

        ones = 0;
        for (int i = 0; i < 64; i++) begin
            look(6'(i));
            if (jump !== 1'b0) ones++;
        end
        check_eq("reset_ctr_sweep", ones, 0);
        lk_pc = 32'hABCD_0014;
        #1;
        check_eq("idx_from_pc", lk_idx, 5);

        // Lookup and taken update on the same entry in one cycle.
        @(negedge clk);
        lk_pc       = pc_for(6'd5);
        upd_valid   = 1'b1;
        upd_idx     = 6'd5;
        upd_taken   = 1'b1;
        #1;
        check_eq("same_cyc_pre", jump, 0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        m_ghr     = {m_ghr[4:0], 1'b1};
        look(6'd5);
        check_eq("same_cyc_post", jump, 1);

        do_upd(6'd5, 1'b1, 1'b0);
        do_upd(6'd5, 1'b1, 1'b0);
        look(6'd5);
        check_eq("ctr3_3taken", jump, 1);
        do_upd(6'd5, 1'b1, 1'b0);
        look(6'd5);
        check_eq("ctr3_4taken", jump, 1);

        do_upd(6'd5, 1'b0, 1'b0); look(6'd5); check_eq("dn_to2", jump, 1);
        do_upd(6'd5, 1'b0, 1'b0); look(6'd5); check_eq("dn_to1", jump, 0);
        do_upd(6'd5, 1'b0, 1'b0); look(6'd5); check_eq("dn_to0", jump, 0);
        do_upd(6'd5, 1'b0, 1'b0); look(6'd5); check_eq("dn_hold0", jump, 0);
        do_upd(6'd5, 1'b1, 1'b0); look(6'd5); check_eq("up_to1", jump, 0);
        do_upd(6'd5, 1'b1, 1'b0); look(6'd5); check_eq("up_to2", jump, 1);
        look(6'd6);
        check_eq("neighbor_idx6", jump, 0);
        check_eq("stat_br_10", stat_branches, 10);
        check_eq("stat_mp_0", stat_mispred, 0);

        @(negedge clk);
        upd_mispred = 1'b1;
        @(posedge clk);
        #1;
        upd_mispred = 1'b0;
        check_eq("mp_no_valid", stat_mispred, 0);
        check_eq("br_no_valid", stat_branches, 10);

        forcer = 2'b11;
        for (int i = 0; i < 10; i++) do_upd(6'd9, 1'b0, 1'b1);
        look(6'd9);
        check_eq("force_t_jump", jump, 1);
        check_eq("force_mp_10", stat_mispred, 10);
        check_eq("force_br_20", stat_branches, 20);
        forcer = 2'b01;
        look(6'd9);
        check_eq("idx9_ctr0", jump, 0);
        forcer = 2'b00;
        look(6'd5);
        check_eq("force_nt_over2", jump, 0);
        forcer = 2'b10;
        look(6'd5);
        check_eq("pred_10_ctr2", jump, 1);

        // Reset dropped between clock edges with an update still pending.
        @(negedge clk);
        upd_valid   = 1'b1;
        upd_idx     = 6'd5;
        upd_taken   = 1'b1;
        upd_mispred = 1'b1;
        @(posedge clk);
        #2;
        check_eq("burst_br_21", stat_branches, 21);
        rst   = 1'b0;
        m_ghr = '0;
        #1;
        check_eq("async_rst_br", stat_branches, 0);
        check_eq("async_rst_mp", stat_mispred, 0);
        check_eq("async_rst_jump", jump, 0);
        @(posedge clk);
        #1;
        check_eq("held_rst_br", stat_branches, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        m_ghr       = {m_ghr[4:0], 1'b1};
        check_eq("first_upd_br", stat_branches, 1);
        check_eq("first_upd_mp", stat_mispred, 1);
        look(6'd5);
        check_eq("ctr_reset_then_up", jump, 1);
        look(6'd9);
        check_eq("idx9_reset_to1", jump, 0);

`ifdef BHP_GSHARE_EN
        do_reset();
        do_upd(6'd1, 1'b1, 1'b0);
        do_upd(6'd2, 1'b1, 1'b0);
        do_upd(6'd3, 1'b0, 1'b0);
        lk_pc = 32'h0000_0040;
        #1;
        check_eq("gshare_idx", lk_idx, 22);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
